// File: rtl/schedule_hazard_ctrl.sv
// Issue controller in front of schedule_1st: per-register in-flight scoreboard plus SYSTEM/CSR serialisation.
// Handshake: an instruction held on CHECK_VALID transfers on a cycle with ISSUE=1; while STALL=1 decode must hold it unchanged.
module schedule_hazard_ctrl #(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 3,
    parameter int TOT_W        = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             MEM_WAIT,
    input  logic             CHECK_VALID,
    input  logic [6:0]       CHECK_OPCODE,
    input  logic [4:0]       CHECK_RD,
    input  logic [4:0]       CHECK_RS1,
    input  logic [4:0]       CHECK_RS2,
    input  logic             CHECK_USE_RS1,
    input  logic             CHECK_USE_RS2,
    input  logic             WB_VALID,
    input  logic [4:0]       WB_RD,
    input  logic             CSR_DONE,
    output logic             STALL,
    output logic             ISSUE,
    output logic [TOT_W-1:0] INFLIGHT,
    output logic             SB_ERR,
    output logic [1:0]       STATE_DBG
);

    localparam logic [6:0]       OPC_SYSTEM = 7'b1110011;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_INFLIGHT);

    // STATE_DBG encoding: 0 idle, 1 draining before a SYSTEM op, 2 waiting for CSR_DONE.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_CSR_BUSY = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt [32];

    logic is_system;
    logic rs1_busy;
    logic rs2_busy;
    logic rd_full;
    logic hazard;
    logic inc;
    logic dec;
    logic wb_under;

    // Entry 0 is never written outside reset/flush, so x0 always reads as idle.
    always_comb begin
        is_system = (CHECK_OPCODE == OPC_SYSTEM);
        rs1_busy  = CHECK_USE_RS1 && (CHECK_RS1 != 5'd0) && (cnt[CHECK_RS1] != '0);
        rs2_busy  = CHECK_USE_RS2 && (CHECK_RS2 != 5'd0) && (cnt[CHECK_RS2] != '0);
        rd_full   = (CHECK_RD != 5'd0) && (cnt[CHECK_RD] == CNT_MAX);
        hazard    = CHECK_VALID && (rs1_busy || rs2_busy || rd_full);
        STALL     = hazard || (state != ST_IDLE)
                  || (CHECK_VALID && is_system && (INFLIGHT != '0));
        ISSUE     = CHECK_VALID && !STALL && !MEM_WAIT && !FLUSH;
        inc       = ISSUE && (CHECK_RD != 5'd0);
        dec       = WB_VALID && (WB_RD != 5'd0) && (cnt[WB_RD] != '0);
        wb_under  = WB_VALID && (WB_RD != 5'd0) && (cnt[WB_RD] == '0);
    end

    assign STATE_DBG = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
            INFLIGHT <= '0;
            SB_ERR   <= 1'b0;
            state    <= ST_IDLE;
        end else if (FLUSH) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
            INFLIGHT <= '0;
            state    <= ST_IDLE;
        end else begin
            if (wb_under) begin
                SB_ERR <= 1'b1;
            end

            // An issue and a retire hitting the same register cancel out.
            for (int i = 1; i < 32; i++) begin
                if (inc && (CHECK_RD == 5'(i)) && !(dec && (WB_RD == 5'(i)))) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (dec && (WB_RD == 5'(i)) && !(inc && (CHECK_RD == 5'(i)))) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end

            if (inc && !dec) begin
                INFLIGHT <= INFLIGHT + TOT_W'(1);
            end else if (dec && !inc) begin
                INFLIGHT <= INFLIGHT - TOT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (CHECK_VALID && is_system) begin
                        if (INFLIGHT != '0) begin
                            state <= ST_DRAIN;
                        end else if (ISSUE) begin
                            state <= ST_CSR_BUSY;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Return to IDLE so the held SYSTEM op is re-evaluated and issues from there.
                    if (INFLIGHT == '0) begin
                        state <= ST_IDLE;
                    end
                end
                ST_CSR_BUSY: begin
                    if (CSR_DONE) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/schedule_hazard_ctrl.md
Name: schedule_hazard_ctrl

Overview:
- Issue controller for the first schedule stage.
- Keeps a per-register in-flight scoreboard and a serialisation FSM for SYSTEM/CSR instructions.
- Drives the STALL that freezes the decode-to-schedule register, and reports which cycles actually issue an instruction.
- Sits between decode stage 2 and schedule_1st; fed back by writeback and CSR-completion strobes.

Parameters:
- CNT_W, 2, width of each per-register in-flight counter.
- MAX_INFLIGHT, 3, per-register counter ceiling (must be ≤ 2^CNT_W - 1); reaching it blocks further writers to that register.
- TOT_W, 7, width of the total in-flight counter (holds up to 31*MAX_INFLIGHT).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- FLUSH  in  1  pipeline flush; synchronous clear of all tracking.
- MEM_WAIT  in  1  memory backpressure; blocks issue and leaves state unchanged.
- CHECK_VALID  in  1  decode presents a valid instruction.
- CHECK_OPCODE  in  7  opcode of the presented instruction.
- CHECK_RD  in  5  destination register.
- CHECK_RS1  in  5  source register 1.
- CHECK_RS2  in  5  source register 2.
- CHECK_USE_RS1  in  1  instruction reads RS1.
- CHECK_USE_RS2  in  1  instruction reads RS2.
- WB_VALID  in  1  writeback retiring one register write.
- WB_RD  in  5  register being retired.
- CSR_DONE  in  1  single-cycle pulse: CSR/SYSTEM op completed.
- STALL  out  1  combinational; hold decode and schedule_1st registers.
- ISSUE  out  1  combinational; instruction accepted this cycle.
- INFLIGHT  out  TOT_W  registered total of outstanding register writes.
- SB_ERR  out  1  sticky error flag: writeback retired a register whose counter was 0.

Behaviour:
- Reset (RST=1, asynchronous): all 31 counters 0, INFLIGHT 0, FSM IDLE, SB_ERR 0. Consequently STALL=0 and ISSUE=0 while CHECK_VALID=0.
- Register x0 is never tracked:
  - RD=0 does not increment.
  - RS=0 never causes a hazard.
  - WB_RD=0 is ignored.
- SYSTEM instruction: CHECK_OPCODE == 7'b1110011.
- hazard = CHECK_VALID and any of the following:
  - (USE_RS1 and cnt[RS1] != 0)
  - (USE_RS2 and cnt[RS2] != 0)
  - (RD != 0 and cnt[RD] == MAX_INFLIGHT)
- STALL = hazard, OR state != IDLE, OR (CHECK_VALID and SYSTEM and INFLIGHT != 0).
- ISSUE = CHECK_VALID and !STALL and !MEM_WAIT and !FLUSH.
- No same-cycle bypass: a writeback clears a hazard starting the following cycle.
- Counter update each edge (when not FLUSH):
  - inc = ISSUE and RD != 0.
  - dec = WB_VALID and WB_RD != 0 and cnt[WB_RD] != 0.
  - inc and dec on the same register: counter unchanged.
  - INFLIGHT += inc - dec. Both together: unchanged.
- Underflow: WB_VALID with WB_RD != 0 and cnt[WB_RD] == 0 sets SB_ERR (held until RST). Counters are unchanged.
- FSM:
  - IDLE: on CHECK_VALID and SYSTEM and !FLUSH:
    - INFLIGHT != 0 → DRAIN.
    - INFLIGHT == 0 and ISSUE → CSR_BUSY.
    - INFLIGHT == 0 and MEM_WAIT → stays IDLE.
  - DRAIN: STALL=1. When INFLIGHT == 0 → IDLE; the SYSTEM instruction is then re-evaluated and issues from IDLE.
  - CSR_BUSY: STALL=1 for every instruction. On CSR_DONE → IDLE. CSR_DONE in any other state is ignored.
  - A SYSTEM instruction with RD != 0 also increments cnt[RD] on issue.
- FLUSH (synchronous, overrides all other inputs): all counters 0, INFLIGHT 0, FSM IDLE, ISSUE=0. SB_ERR is preserved.
- MEM_WAIT: ISSUE=0 and no increments. Writebacks and CSR_DONE are still processed.
- RST asserted mid-operation immediately returns all state to reset values regardless of CLK.

Test Plan:
- Back-to-back RAW:
  - Issue RD=5, next cycle CHECK RS1=5 → STALL=1, INFLIGHT=1.
  - WB_VALID with WB_RD=5 → STALL=0 on the following cycle, ISSUE=1.
- Writer saturation: three issues to RD=7 without writeback → cnt=3; a 4th writer to RD=7 gets STALL=1. One WB → issues next cycle.
- Same-cycle issue of RD=3 and WB of RD=3 with cnt[3]=1 → cnt[3] stays 1, INFLIGHT unchanged.
- CSR serialisation:
  - SYSTEM presented with INFLIGHT=2 → DRAIN, STALL=1.
  - Two WBs → IDLE, ISSUE=1 → CSR_BUSY; subsequent ADD stalls.
  - CSR_DONE pulse → IDLE, ADD issues the next cycle.
- FLUSH while in CSR_BUSY with INFLIGHT=4 → next cycle INFLIGHT=0, FSM IDLE, STALL=0. A dependent instruction on a previously busy register issues immediately.
- Underflow / x0 / reset:
  - WB_RD=9 with cnt[9]=0 → SB_ERR=1, survives FLUSH.
  - RD=0 issue → INFLIGHT unchanged.
  - Asynchronous RST pulse mid-cycle → SB_ERR=0 and INFLIGHT=0 immediately.
